vga_pattern_gen: RTL and testbench

Parametrised VGA timing generator with a built-in multi-mode test-pattern source. It is the next-generation replacement for the fixed 640x480 timing-plus-single-pattern pairing in the VGA example tops. All outputs are registered and mutually aligned. Mode changes are frame-synchronous, and one animated mode (bouncing box) exercises per-frame state. It sits directly behind the PLL-derived pixel clock and drives the board's RGB and sync pins.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_timing.sv | 57 +++++
 rtl/vga_pattern_gen.sv | 136 +++++++++++++
 tb/tb_vga_pattern_gen.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared mode encodings, 640x480@60 default timing and the box bounce step.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_BARS    = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_BOX     = 2'd3
    } mode_e;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // Returns {dir, pos}; the boundary value is reached, then the next step reverses.
    function automatic logic [10:0] bounce(input logic [9:0] pos, input logic up,
                                           input logic [9:0] lim);
        if (up) return (pos >= lim) ? {1'b0, pos - 10'd1} : {1'b1, pos + 10'd1};
        else    return (pos == '0)  ? {1'b1, pos + 10'd1} : {1'b0, pos - 10'd1};
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Stage-0 raster counters with combinational sync/visible decode.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic       clk_i,
    input  logic       reset_ni,
    output logic [9:0] col_o,
    output logic [9:0] row_o,
    output logic       hact_o,
    output logic       vact_o,
    output logic       vis_o,
    output logic       frame_start_o
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] col_q, col_d, row_q, row_d;

    always_comb begin
        col_d = col_q + 10'd1;
        row_d = row_q;
        if (col_q == 10'(H_TOTAL - 1)) begin
            col_d = '0;
            row_d = (row_q == 10'(V_TOTAL - 1)) ? '0 : row_q + 10'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col_o         = col_q;
    assign row_o         = row_q;
    assign hact_o        = (col_q >= HS_BEG) && (col_q < HS_END);
    assign vact_o        = (row_q >= VS_BEG) && (row_q < VS_END);
    assign vis_o         = (col_q < 10'(H_VISIBLE)) && (row_q < 10'(V_VISIBLE));
    assign frame_start_o = (col_q == '0) && (row_q == '0);
endmodule

// File: rtl/vga_pattern_gen.sv
// VGA timing plus multi-mode test pattern; every output registered once behind stage 0.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int COLOR_BITS  = 4,
    parameter int H_VISIBLE   = DEF_H_VISIBLE,
    parameter int H_FRONT     = DEF_H_FRONT,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BACK      = DEF_H_BACK,
    parameter int V_VISIBLE   = DEF_V_VISIBLE,
    parameter int V_FRONT     = DEF_V_FRONT,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_BACK      = DEF_V_BACK,
    parameter bit SYNC_POL    = 1'b0,
    parameter int CHECK_SHIFT = 5,
    parameter int BOX_SIZE    = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic [1:0]            mode_i,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  visible_o,
    output logic [9:0]            column_o,
    output logic [9:0]            row_o,
    output logic [COLOR_BITS-1:0] red_o,
    output logic [COLOR_BITS-1:0] green_o,
    output logic [COLOR_BITS-1:0] blue_o,
    output logic                  frame_start_o
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int BAR_W   = H_VISIBLE / 8;
    localparam logic [COLOR_BITS-1:0] F = '1;
    localparam logic [9:0] X_MAX = 10'(H_VISIBLE - BOX_SIZE);
    localparam logic [9:0] Y_MAX = 10'(V_VISIBLE - BOX_SIZE);

    logic [9:0] col, row;
    logic       hact, vact, vis, fs;

    vga_timing #(
        .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
        .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
    ) u_timing (
        .clk_i(clk_i), .reset_ni(reset_ni), .col_o(col), .row_o(row),
        .hact_o(hact), .vact_o(vact), .vis_o(vis), .frame_start_o(fs)
    );

    mode_e      mode_q, mode_d, cur_mode;
    logic [2:0] bar_q, bar_d;
    logic [9:0] bar_pos_q, bar_pos_d;
    logic [9:0] box_x_q, box_x_d, box_y_q, box_y_d;
    logic       dx_q, dx_d, dy_q, dy_d;
    logic       in_box;
    logic [COLOR_BITS-1:0] r_d, g_d, b_d;

    // The pixel at (0,0) already uses the freshly sampled mode.
    assign cur_mode = fs ? mode_e'(mode_i) : mode_q;
    assign mode_d   = cur_mode;
    assign in_box   = ({1'b0, col} >= {1'b0, box_x_q}) && ({1'b0, col} < {1'b0, box_x_q} + 11'(BOX_SIZE))
                   && ({1'b0, row} >= {1'b0, box_y_q}) && ({1'b0, row} < {1'b0, box_y_q} + 11'(BOX_SIZE));

    // bar_q/bar_pos_q track the stage-0 column, so they advance with it.
    always_comb begin
        bar_d     = bar_q;
        bar_pos_d = bar_pos_q + 10'd1;
        if (col == 10'(H_TOTAL - 1)) begin
            bar_d     = '0;
            bar_pos_d = '0;
        end else if (bar_pos_q == 10'(BAR_W - 1)) begin
            bar_d     = bar_q + 3'd1;
            bar_pos_d = '0;
        end
    end

    always_comb begin
        {dx_d, box_x_d} = {dx_q, box_x_q};
        {dy_d, box_y_d} = {dy_q, box_y_q};
        if (col == '0 && row == 10'(V_VISIBLE)) begin
            {dx_d, box_x_d} = bounce(box_x_q, dx_q, X_MAX);
            {dy_d, box_y_d} = bounce(box_y_q, dy_q, Y_MAX);
        end
    end

    always_comb begin
        r_d = '0;
        g_d = '0;
        b_d = '0;
        if (vis) begin
            unique case (cur_mode)
                MODE_SOLID:   {r_d, g_d, b_d} = {F, F, F};
                MODE_BARS:    {r_d, g_d, b_d} = {bar_q[2] ? F : '0, bar_q[1] ? F : '0, bar_q[0] ? F : '0};
                MODE_CHECKER: if (col[CHECK_SHIFT] ^ row[CHECK_SHIFT]) {r_d, g_d, b_d} = {F, F, F};
                MODE_BOX:     if (in_box) {r_d, g_d, b_d} = {F, F, F};
                default:      ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            mode_q        <= MODE_SOLID;
            bar_q         <= '0;
            bar_pos_q     <= '0;
            box_x_q       <= '0;
            box_y_q       <= '0;
            dx_q          <= 1'b1;
            dy_q          <= 1'b1;
            hsync_o       <= ~SYNC_POL;
            vsync_o       <= ~SYNC_POL;
            visible_o     <= 1'b0;
            column_o      <= '0;
            row_o         <= '0;
            red_o         <= '0;
            green_o       <= '0;
            blue_o        <= '0;
            frame_start_o <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            bar_q         <= bar_d;
            bar_pos_q     <= bar_pos_d;
            box_x_q       <= box_x_d;
            box_y_q       <= box_y_d;
            dx_q          <= dx_d;
            dy_q          <= dy_d;
            hsync_o       <= hact ? SYNC_POL : ~SYNC_POL;
            vsync_o       <= vact ? SYNC_POL : ~SYNC_POL;
            visible_o     <= vis;
            column_o      <= col;
            row_o         <= row;
            red_o         <= r_d;
            green_o       <= g_d;
            blue_o        <= b_d;
            frame_start_o <= fs;
        end
    end
endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench on a shrunken 24x16 raster (16x12 visible, 2-px bars, 4-px checks, 4-px box).
module tb_vga_pattern_gen;
    localparam int HT = 24;
    localparam int FR = HT * 16;

    logic       clk = 1'b0;
    logic       reset_ni = 1'b0;
    logic [1:0] mode_i = 2'd0;
    logic       hsync_o, vsync_o, visible_o, frame_start_o;
    logic [9:0] column_o, row_o;
    logic [3:0] red_o, green_o, blue_o;

    int total = 0;
    int bad   = 0;
    int cur   = -1;

    vga_pattern_gen #(
        .COLOR_BITS(4), .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(12), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_POL(1'b0), .CHECK_SHIFT(2), .BOX_SIZE(4)
    ) dut (
        .clk_i(clk), .reset_ni(reset_ni), .mode_i(mode_i),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .visible_o(visible_o),
        .column_o(column_o), .row_o(row_o),
        .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
        .frame_start_o(frame_start_o)
    );

    always #5 clk = ~clk;

    function automatic int px(input int f, input int c, input int r);
        return f * FR + r * HT + c;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go(input int target);
        repeat (target - cur) @(posedge clk);
        #1;
        cur = target;
    endtask

    task automatic pix(input string tag, input int f, input int c, input int r,
                       input logic [11:0] exp);
        go(px(f, c, r));
        chk({tag, "_rgb"}, {red_o, green_o, blue_o}, exp);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_sync"},  {hsync_o, vsync_o}, 2'b11);
        chk({tag, "_vis"},   {visible_o, frame_start_o}, 2'b00);
        chk({tag, "_pos"},   {column_o, row_o}, 20'd0);
        chk({tag, "_rgb"},   {red_o, green_o, blue_o}, 12'h000);
    endtask

    logic [11:0] bars [8];

    initial begin
        bars = '{12'h000, 12'h00F, 12'h0F0, 12'h0FF, 12'hF00, 12'hF0F, 12'hFF0, 12'hFFF};

        repeat (3) @(posedge clk);
        #1;
        chk_reset("in_reset");
        reset_ni = 1'b1;
        #1;
        chk_reset("after_release");

        // Frame 0, solid; timing checks
        go(0);
        chk("first_pix_pos", {column_o, row_o, frame_start_o, visible_o}, {10'd0, 10'd0, 2'b11});
        chk("first_pix_rgb", {red_o, green_o, blue_o}, 12'hFFF);
        go(1);
        chk("pix1", {column_o, frame_start_o}, {10'd1, 1'b0});
        go(16);
        chk("hblank_vis", {visible_o, red_o, green_o, blue_o}, 13'h0000);
        go(17); chk("hs_17", hsync_o, 1'b1);
        go(18); chk("hs_18", hsync_o, 1'b0);
        go(20); chk("hs_20", hsync_o, 1'b0);
        go(21); chk("hs_21", hsync_o, 1'b1);
        go(23); chk("col_23", column_o, 10'd23);
        go(px(0, 0, 1)); chk("row_wrap", {column_o, row_o}, {10'd0, 10'd1});
        pix("solid_r5", 0, 3, 5, 12'hFFF);
        mode_i = 2'd1;
        pix("latch_r6", 0, 3, 6, 12'hFFF);
        go(px(0, 0, 12)); chk("vblank_vis", {visible_o, row_o}, {1'b0, 10'd12});
        go(px(0, 23, 12)); chk("vs_12", vsync_o, 1'b1);
        go(px(0, 5, 13)); chk("vs_13", vsync_o, 1'b0);
        go(px(0, 23, 14)); chk("vs_14", vsync_o, 1'b0);
        go(px(0, 0, 15)); chk("vs_15", vsync_o, 1'b1);
        go(px(0, 23, 15)); chk("fs_last", frame_start_o, 1'b0);

        // Frame 1, colour bars
        go(px(1, 0, 0));
        chk("fs_frame1", {frame_start_o, column_o, row_o}, {1'b1, 20'd0});
        for (int b = 0; b < 8; b++) pix("bar", 1, 2 * b, 0, bars[b]);
        pix("bar_last", 1, 15, 0, 12'hFFF);
        pix("bar_hblank", 1, 16, 0, 12'h000);
        pix("bar_r3", 1, 5, 3, 12'h0F0);
        mode_i = 2'd2;
        pix("bar_latch", 1, 5, 4, 12'h0F0);

        // Frame 2, checkerboard
        pix("chk_0_0", 2, 0, 0, 12'h000);
        pix("chk_4_0", 2, 4, 0, 12'hFFF);
        pix("chk_0_4", 2, 0, 4, 12'hFFF);
        pix("chk_4_4", 2, 4, 4, 12'h000);
        mode_i = 2'd3;

        // Frames 3..13, bouncing box (x=y=f until y bounces at 8, x at 12)
        pix("f3_3_2", 3, 3, 2, 12'h000);
        pix("f3_2_3", 3, 2, 3, 12'h000);
        pix("f3_3_3", 3, 3, 3, 12'hFFF);
        pix("f3_7_3", 3, 7, 3, 12'h000);
        pix("f3_6_6", 3, 6, 6, 12'hFFF);
        pix("f3_3_7", 3, 3, 7, 12'h000);
        pix("f8_8_7", 8, 8, 7, 12'h000);
        pix("f8_7_8", 8, 7, 8, 12'h000);
        pix("f8_8_8", 8, 8, 8, 12'hFFF);
        pix("f8_11_11", 8, 11, 11, 12'hFFF);
        pix("f9_9_6", 9, 9, 6, 12'h000);
        pix("f9_8_7", 9, 8, 7, 12'h000);
        pix("f9_9_7", 9, 9, 7, 12'hFFF);
        pix("f12_11_4", 12, 11, 4, 12'h000);
        pix("f12_12_4", 12, 12, 4, 12'hFFF);
        pix("f12_15_7", 12, 15, 7, 12'hFFF);
        pix("f13_10_3", 13, 10, 3, 12'h000);
        pix("f13_11_3", 13, 11, 3, 12'hFFF);
        pix("f13_15_3", 13, 15, 3, 12'h000);

        // Mid-frame async reset
        go(px(13, 0, 8));
        #2 reset_ni = 1'b0;
        #1 chk_reset("async_rst");
        repeat (3) @(posedge clk);
        #1 chk_reset("rst_hold");
        reset_ni = 1'b1;
        #1 chk_reset("rst_release");
        cur = -1;
        go(0);
        chk("restart_pos", {frame_start_o, column_o, row_o}, {1'b1, 20'd0});
        chk("restart_box", {red_o, green_o, blue_o}, 12'hFFF);
        pix("restart_4_0", 0, 4, 0, 12'h000);
        pix("restart_3_3", 0, 3, 3, 12'hFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
